// File: rtl/led_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_seq
// Purpose  : Four-pattern sequencer for the 8 green + 10 red board LEDs.
//            Built-in step prescaler, debounced mode pushbutton, pause switch.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_seq #(
    parameter int TICK_DIV   = 50000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       pause,
    output logic [7:0] LEDG,
    output logic [9:0] LEDR,
    output logic [1:0] mode,
    output logic       step_tick
);

    localparam int c_PW = $clog2(TICK_DIV);
    localparam int c_DW = $clog2(DEB_CYCLES);
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [c_PW-1:0] c_PRESC_ONE = c_PW'(1);
    localparam logic [c_DW-1:0] c_DEB_MAX   = c_DW'(DEB_CYCLES - 1);
    localparam logic [c_DW-1:0] c_DEB_ONE   = c_DW'(1);
    localparam logic [4:0]      c_POS_MAX   = 5'd17;
    localparam logic [4:0]      c_FILL_MAX  = 5'd18;
    localparam logic [17:0]     c_V_ALT0    = {10'h3FF, 8'h00};

    typedef enum logic [1:0] {
        MODE_ALT    = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_t;

    // Prescaler and button path
    logic [c_PW-1:0] r_presc;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_deb;
    logic [c_DW-1:0] r_deb_cnt;

    // Pattern state and registered outputs
    mode_t           r_mode;
    logic            r_lighton;
    logic [4:0]      r_pos;
    logic            r_dir;        // 1 = moving up
    logic [4:0]      r_fill;
    logic [7:0]      r_ledg;
    logic [9:0]      r_ledr;
    logic            r_step_tick;

    // Combinational next-state terms
    logic            w_tick;
    logic            w_press;
    mode_t           w_mode_inc;
    logic [17:0]     w_init_v;
    logic            w_lighton_nxt;
    logic [4:0]      w_pos_nxt;
    logic            w_dir_nxt;
    logic [4:0]      w_fill_nxt;
    logic [17:0]     w_v_nxt;

    function automatic logic [17:0] f_onehot(input logic [4:0] p);
        return 18'd1 << p;
    endfunction

    function automatic logic [17:0] f_fillmask(input logic [4:0] f);
        logic [18:0] t;
        t = (19'd1 << f) - 19'd1;
        return t[17:0];
    endfunction

    // A step happens only at the end of a full, unpaused prescaler period
    assign w_tick = (r_presc == c_PRESC_MAX) && !pause;

    // Rising edge of the debounced level: accepted on the edge it is committed
    assign w_press = !r_deb && r_sync2 && (r_deb_cnt == c_DEB_MAX);

    assign w_mode_inc = mode_t'(r_mode + 2'd1);

    // Initial LED image of the mode being entered
    always_comb begin
        w_init_v = 18'd0;
        case (w_mode_inc)
            MODE_ALT:    w_init_v = c_V_ALT0;
            MODE_CHASE:  w_init_v = 18'd1;
            MODE_BOUNCE: w_init_v = 18'd1;
            MODE_FILL:   w_init_v = 18'd0;
            default:     w_init_v = 18'd0;
        endcase
    end

    // Next pattern state and LED image for one step of the current mode
    always_comb begin
        w_lighton_nxt = r_lighton;
        w_pos_nxt     = r_pos;
        w_dir_nxt     = r_dir;
        w_fill_nxt    = r_fill;
        w_v_nxt       = {r_ledr, r_ledg};
        case (r_mode)
            MODE_ALT: begin
                w_lighton_nxt = ~r_lighton;
                w_v_nxt       = {{10{r_lighton}}, {8{~r_lighton}}};
            end
            MODE_CHASE: begin
                w_pos_nxt = (r_pos == c_POS_MAX) ? 5'd0 : r_pos + 5'd1;
                w_v_nxt   = f_onehot(w_pos_nxt);
            end
            MODE_BOUNCE: begin
                // Reversal happens on the step after reaching an end, so each
                // end position is displayed for exactly one step
                if (r_dir) begin
                    if (r_pos == c_POS_MAX) begin
                        w_dir_nxt = 1'b0;
                        w_pos_nxt = r_pos - 5'd1;
                    end else begin
                        w_pos_nxt = r_pos + 5'd1;
                    end
                end else begin
                    if (r_pos == 5'd0) begin
                        w_dir_nxt = 1'b1;
                        w_pos_nxt = r_pos + 5'd1;
                    end else begin
                        w_pos_nxt = r_pos - 5'd1;
                    end
                end
                w_v_nxt = f_onehot(w_pos_nxt);
            end
            MODE_FILL: begin
                w_fill_nxt = (r_fill == c_FILL_MAX) ? 5'd0 : r_fill + 5'd1;
                w_v_nxt    = f_fillmask(w_fill_nxt);
            end
            default: begin
                w_v_nxt = {r_ledr, r_ledg};
            end
        endcase
    end

    // Step prescaler: restarts on a mode change, frozen while paused
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_press || w_tick) begin
            r_presc <= '0;
        end else if (!pause) begin
            r_presc <= r_presc + c_PRESC_ONE;
        end
    end

    // Button synchroniser and stable-level debouncer
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_deb     <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= mode_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == c_DEB_MAX) begin
                r_deb     <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
            end
        end
    end

    // Mode/pattern state machine; a mode change overrides a coincident tick
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_mode      <= MODE_ALT;
            r_lighton   <= 1'b0;
            r_pos       <= 5'd0;
            r_dir       <= 1'b1;
            r_fill      <= 5'd0;
            r_ledg      <= c_V_ALT0[7:0];
            r_ledr      <= c_V_ALT0[17:8];
            r_step_tick <= 1'b0;
        end else if (w_press) begin
            r_mode      <= w_mode_inc;
            r_lighton   <= 1'b0;
            r_pos       <= 5'd0;
            r_dir       <= 1'b1;
            r_fill      <= 5'd0;
            r_ledg      <= w_init_v[7:0];
            r_ledr      <= w_init_v[17:8];
            r_step_tick <= 1'b0;
        end else if (w_tick) begin
            r_lighton   <= w_lighton_nxt;
            r_pos       <= w_pos_nxt;
            r_dir       <= w_dir_nxt;
            r_fill      <= w_fill_nxt;
            r_ledg      <= w_v_nxt[7:0];
            r_ledr      <= w_v_nxt[17:8];
            r_step_tick <= 1'b1;
        end else begin
            r_step_tick <= 1'b0;
        end
    end

    assign LEDG      = r_ledg;
    assign LEDR      = r_ledr;
    assign mode      = r_mode;
    assign step_tick = r_step_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_seq
// Purpose  : Self-checking bench for led_pattern_seq (TICK_DIV=4, DEB_CYCLES=3)
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_seq;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       pau;
    logic [7:0] LEDG;
    logic [9:0] LEDR;
    logic [1:0] mode;
    logic       step_tick;

    int n_checks = 0;
    int n_fail   = 0;

    led_pattern_seq #(
        .TICK_DIV   (4),
        .DEB_CYCLES (3)
    ) u_dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .mode_btn  (btn),
        .pause     (pau),
        .LEDG      (LEDG),
        .LEDR      (LEDR),
        .mode      (mode),
        .step_tick (step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        btn;
        logic        pau;
        logic [17:0] v;
        logic [1:0]  m;
        logic        st;
    } vec_t;

    localparam logic [17:0] c_ALT0 = 18'h3FF00;
    localparam logic [17:0] c_ALT1 = 18'h000FF;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [17:0] ev, input logic [1:0] em, input logic est);
        n_checks++;
        if ({LEDR, LEDG} !== ev || mode !== em || step_tick !== est) begin
            n_fail++;
            $display("FAIL %s: got V=%05h mode=%0d step_tick=%0b, expected V=%05h mode=%0d step_tick=%0b",
                     nm, {LEDR, LEDG}, mode, step_tick, ev, em, est);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Raise the button, wait (bounded) for the mode change, then release
    task automatic press(input string nm, input logic [1:0] em, input logic [17:0] ev);
        int lat;
        lat = 0;
        btn = 1'b1;
        while (mode !== em && lat < 20) begin
            step(1);
            lat++;
        end
        btn = 1'b0;
        chk_int({nm, " latency"}, lat, 5);
        chk(nm, ev, em, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        vec_t        vecs[11];
        logic [17:0] one;
        logic [17:0] ev;
        logic [18:0] t;
        int          p;

        vecs[0]  = '{0, 1'b0, 1'b0, c_ALT0,   2'd0, 1'b0};
        vecs[1]  = '{3, 1'b0, 1'b0, c_ALT0,   2'd0, 1'b0};
        vecs[2]  = '{1, 1'b0, 1'b0, c_ALT1,   2'd0, 1'b1};
        vecs[3]  = '{1, 1'b0, 1'b0, c_ALT1,   2'd0, 1'b0};
        vecs[4]  = '{3, 1'b0, 1'b0, c_ALT0,   2'd0, 1'b1};
        vecs[5]  = '{4, 1'b1, 1'b0, c_ALT1,   2'd0, 1'b1};
        vecs[6]  = '{1, 1'b1, 1'b0, 18'h00001, 2'd1, 1'b0};
        vecs[7]  = '{3, 1'b1, 1'b0, 18'h00001, 2'd1, 1'b0};
        vecs[8]  = '{1, 1'b1, 1'b0, 18'h00002, 2'd1, 1'b1};
        vecs[9]  = '{4, 1'b0, 1'b0, 18'h00004, 2'd1, 1'b1};
        vecs[10] = '{4, 1'b0, 1'b0, 18'h00008, 2'd1, 1'b1};

        one = 18'd1;
        btn = 1'b0;
        pau = 1'b0;
        do_reset();

        // Reset state, ALT stepping, first press held
        for (int i = 0; i < 11; i++) begin
            btn = vecs[i].btn;
            pau = vecs[i].pau;
            step(vecs[i].cyc);
            chk($sformatf("vec%0d", i), vecs[i].v, vecs[i].m, vecs[i].st);
        end

        // CHASE continues from pos 3 through the 17 -> 0 wrap
        for (int k = 4; k <= 18; k++) begin
            step(4);
            ev = one << (k % 18);
            chk($sformatf("chase tick %0d", k), ev, 2'd1, 1'b1);
        end

        // Two-cycle glitch must be ignored
        btn = 1'b1;
        step(2);
        btn = 1'b0;
        step(2);
        chk("glitch ignored", 18'h00002, 2'd1, 1'b1);

        // Pause with the prescaler at its last count: no tick until released
        step(3);
        chk("pre-pause", 18'h00002, 2'd1, 1'b0);
        pau = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk($sformatf("paused %0d", i), 18'h00002, 2'd1, 1'b0);
        end
        pau = 1'b0;
        step(1);
        chk("unpause tick", 18'h00004, 2'd1, 1'b1);

        // BOUNCE: two presses from reset, 40 ticks
        do_reset();
        chk("reset2", c_ALT0, 2'd0, 1'b0);
        press("press to chase", 2'd1, 18'h00001);
        step(6);
        press("press to bounce", 2'd2, 18'h00001);
        for (int k = 1; k <= 40; k++) begin
            step(4);
            p  = k % 34;
            p  = (p <= 17) ? p : 34 - p;
            ev = one << p;
            chk($sformatf("bounce tick %0d", k), ev, 2'd2, 1'b1);
        end

        // FILL: 20 ticks, wraps to empty after full
        press("press to fill", 2'd3, 18'h00000);
        for (int k = 1; k <= 20; k++) begin
            step(4);
            t  = (19'd1 << (k % 19)) - 19'd1;
            ev = t[17:0];
            chk($sformatf("fill tick %0d", k), ev, 2'd3, 1'b1);
        end

        // Mode index wraps 3 -> 0
        press("press wrap", 2'd0, c_ALT0);

        // Press accepted on the same edge as a tick
        step(7);
        btn = 1'b1;
        step(4);
        chk("before coincident press", c_ALT0, 2'd0, 1'b0);
        step(1);
        chk("coincident press", 18'h00001, 2'd1, 1'b0);
        btn = 1'b0;
        step(3);
        chk("after coincident press", 18'h00001, 2'd1, 1'b0);
        step(1);
        chk("first tick after coincident", 18'h00002, 2'd1, 1'b1);

        // Reset mid-pattern in BOUNCE, sampled on a tick edge
        step(4);
        press("press to bounce 2", 2'd2, 18'h00001);
        step(23);
        chk("bounce before reset", 18'h00020, 2'd2, 1'b0);
        rst = 1'b1;
        step(1);
        chk("reset mid-pattern", c_ALT0, 2'd0, 1'b0);
        step(1);
        rst = 1'b0;
        chk("reset held", c_ALT0, 2'd0, 1'b0);
        step(4);
        chk("tick after reset", c_ALT1, 2'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
